parity_frame_gen: RTL and testbench

Streaming parity generator that replaces the fixed 9-bit combinational parity cell with a parametrised, handshaked datapath. It accepts words of DATA_W bits on a valid/ready input and emits each word with its per-word parity bit (even or odd, set at elaboration). After the last word of a frame it appends one trailer beat carrying the longitudinal (column-XOR) parity of the frame. It sits between a data source and a serial or memory link that needs per-word and per-frame parity.

---
 rtl/parity_frame_gen_if.sv | 27 ++
 rtl/parity_frame_gen.sv | 100 ++++++++++
 tb/tb_parity_frame_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_gen_if.sv
// Handshake bundle for parity_frame_gen: the input word stream and the output beat stream.
interface parity_frame_gen_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_last;
  logic              out_trailer;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_last, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_last, out_trailer, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par, out_last, out_trailer, out_err
  );
endinterface

// File: rtl/parity_frame_gen.sv
// Streaming per-word parity generator that appends a longitudinal (column-XOR) parity trailer to each frame.
// Optional receive-side parity checker is compiled in when PARITY_CHECK_EN is defined.
module parity_frame_gen #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int LEN_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  parity_frame_gen_if.slave  bus,
  output logic [LEN_W-1:0]   frame_len,
  output logic [7:0]         err_cnt
);

  localparam logic [1:0]       IDLE     = 2'd0;
  localparam logic [1:0]       BODY     = 2'd1;
  localparam logic [1:0]       TRAILER  = 2'd2;
  localparam logic             ODD_BIT  = (ODD != 0);
  localparam logic [LEN_W-1:0] WCNT_MAX = '1;

  logic [1:0]        state;
  logic [DATA_W-1:0] lrc;
  logic [LEN_W-1:0]  wcnt;
  logic              stage_free;
  logic              data_acc;
  logic              trl_load;

  // The trailer owns the output stage for one load, so input is refused while it is pending.
  assign stage_free   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = stage_free && (state != TRAILER);
  assign data_acc     = bus.in_valid && bus.in_ready;
  assign trl_load     = stage_free && (state == TRAILER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      lrc             <= '0;
      wcnt            <= '0;
      frame_len       <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_par     <= 1'b0;
      bus.out_last    <= 1'b0;
      bus.out_trailer <= 1'b0;
    end else if (data_acc) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= bus.in_data;
      bus.out_par     <= (^bus.in_data) ^ ODD_BIT;
      bus.out_last    <= 1'b0;
      bus.out_trailer <= 1'b0;
      lrc             <= lrc ^ bus.in_data;
      if (wcnt != WCNT_MAX) begin
        wcnt <= wcnt + 1'b1;
      end
      state <= bus.in_last ? TRAILER : BODY;
    end else if (trl_load) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= lrc;
      bus.out_par     <= (^lrc) ^ ODD_BIT;
      bus.out_last    <= 1'b1;
      bus.out_trailer <= 1'b1;
      frame_len       <= wcnt;
      lrc             <= '0;
      wcnt            <= '0;
      state           <= IDLE;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  localparam logic [7:0] ERR_MAX = 8'hFF;

  logic mismatch;

  assign mismatch = bus.in_par != ((^bus.in_data) ^ ODD_BIT);

  // The error flag travels with its data beat; trailer beats never carry an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_err <= 1'b0;
      err_cnt     <= '0;
    end else if (data_acc) begin
      bus.out_err <= mismatch;
      if (mismatch && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (trl_load) begin
      bus.out_err <= 1'b0;
    end
  end
`else
  logic unused_par;

  assign unused_par  = bus.in_par;
  assign bus.out_err = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_parity_frame_gen.sv
// Randomized self-checking bench for parity_frame_gen: two instances (even/8-bit count, odd/2-bit count)
// share one stimulus stream and are scored against a frame-level reference model.
module tb_parity_frame_gen;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_par = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  logic [7:0] frame_len_a;
  logic [1:0] frame_len_b;
  logic [7:0] err_cnt_a;
  logic [7:0] err_cnt_b;

  int errors = 0;
  int checks = 0;

  parity_frame_gen_if #(.DATA_W(DATA_W)) bus_a ();
  parity_frame_gen_if #(.DATA_W(DATA_W)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.in_par    = in_par;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.in_par    = in_par;
  assign bus_b.out_ready = out_ready;

  parity_frame_gen #(.DATA_W(DATA_W), .ODD(0), .LEN_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.slave),
    .frame_len (frame_len_a),
    .err_cnt   (err_cnt_a)
  );

  parity_frame_gen #(.DATA_W(DATA_W), .ODD(1), .LEN_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b.slave),
    .frame_len (frame_len_b),
    .err_cnt   (err_cnt_b)
  );

  always #5 clk = ~clk;

  // Gather both instances' outputs into arrays so checks can loop over them.
  logic [DATA_W-1:0] o_data  [2];
  logic              o_valid [2];
  logic              o_par   [2];
  logic              o_last  [2];
  logic              o_trl   [2];
  logic              o_err   [2];
  logic              i_ready [2];
  logic [7:0]        o_flen  [2];
  logic [7:0]        o_ecnt  [2];

  assign o_data[0]  = bus_a.out_data;
  assign o_data[1]  = bus_b.out_data;
  assign o_valid[0] = bus_a.out_valid;
  assign o_valid[1] = bus_b.out_valid;
  assign o_par[0]   = bus_a.out_par;
  assign o_par[1]   = bus_b.out_par;
  assign o_last[0]  = bus_a.out_last;
  assign o_last[1]  = bus_b.out_last;
  assign o_trl[0]   = bus_a.out_trailer;
  assign o_trl[1]   = bus_b.out_trailer;
  assign o_err[0]   = bus_a.out_err;
  assign o_err[1]   = bus_b.out_err;
  assign i_ready[0] = bus_a.in_ready;
  assign i_ready[1] = bus_b.in_ready;
  assign o_flen[0]  = frame_len_a;
  assign o_flen[1]  = {6'd0, frame_len_b};
  assign o_ecnt[0]  = err_cnt_a;
  assign o_ecnt[1]  = err_cnt_b;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected output beats in order, built from accepted words.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [1:0]        err;
    int                ecnt_a;
    int                ecnt_b;
    int                nwords;
  } beat_t;

  beat_t             sb [$];
  logic [DATA_W-1:0] frame_words [$];
  int                err_total [2];
  beat_t             b;
  logic              pend_vis;
  logic [DATA_W-1:0] pend_data;
  logic              held [2];
  logic [DATA_W-1:0] held_data [2];
  logic              held_par [2];
  logic              held_last [2];

  function automatic logic expPar(input logic [DATA_W-1:0] v, input int d);
    int ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(v[i]);
    return (d == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic int lenMax(input int d);
    return (d == 1) ? 3 : 255;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      frame_words.delete();
      err_total = '{0, 0};
      pend_vis  = 1'b0;
      held      = '{1'b0, 1'b0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pend_vis) begin
          checkOutput($sformatf("latency_valid[%0d]", d), o_valid[d], 1);
          checkOutput($sformatf("latency_data[%0d]", d), o_data[d], pend_data);
        end
        if (held[d]) begin
          checkOutput($sformatf("hold_data[%0d]", d), o_data[d], held_data[d]);
          checkOutput($sformatf("hold_par[%0d]", d), o_par[d], held_par[d]);
          checkOutput($sformatf("hold_last[%0d]", d), o_last[d], held_last[d]);
        end
      end
      checkOutput("valid_match", o_valid[1], o_valid[0]);
      checkOutput("ready_match", i_ready[1], i_ready[0]);

      if (o_valid[0] && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", o_valid[0], 0);
        end else begin
          b = sb.pop_front();
          for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("data[%0d]", d), o_data[d], b.data);
            checkOutput($sformatf("par[%0d]", d), o_par[d], expPar(b.data, d));
            checkOutput($sformatf("last[%0d]", d), o_last[d], b.last);
            checkOutput($sformatf("trailer[%0d]", d), o_trl[d], b.last);
            checkOutput($sformatf("err[%0d]", d), o_err[d], b.err[d]);
            checkOutput($sformatf("err_cnt[%0d]", d), o_ecnt[d], (d == 0) ? b.ecnt_a : b.ecnt_b);
            if (b.last) begin
              checkOutput($sformatf("frame_len[%0d]", d), o_flen[d],
                          (b.nwords > lenMax(d)) ? lenMax(d) : b.nwords);
            end
          end
        end
      end

      for (int d = 0; d < 2; d++) begin
        held[d]      = o_valid[d] && !out_ready;
        held_data[d] = o_data[d];
        held_par[d]  = o_par[d];
        held_last[d] = o_last[d];
      end

      pend_vis = 1'b0;
      if (in_valid && i_ready[0]) begin
        beat_t w;
        w.data   = in_data;
        w.last   = 1'b0;
        w.nwords = 0;
        for (int d = 0; d < 2; d++) begin
          logic bad;
`ifdef PARITY_CHECK_EN
          bad = (in_par != expPar(in_data, d));
`else
          bad = 1'b0;
`endif
          w.err[d] = bad;
          if (bad && err_total[d] < 255) err_total[d]++;
        end
        w.ecnt_a = err_total[0];
        w.ecnt_b = err_total[1];
        sb.push_back(w);
        frame_words.push_back(in_data);
        pend_vis  = 1'b1;
        pend_data = in_data;
        if (in_last) begin
          beat_t t;
          t.data = '0;
          foreach (frame_words[i]) t.data = t.data ^ frame_words[i];
          t.last   = 1'b1;
          t.err    = 2'b00;
          t.ecnt_a = err_total[0];
          t.ecnt_b = err_total[1];
          t.nwords = frame_words.size();
          sb.push_back(t);
          frame_words.delete();
        end
      end
    end
  end

  // Offer one word and hold it until accepted; called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic l, input logic p, input int rdy_pct);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_par   = p;
    while (!done) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (i_ready[0]) begin
        done = 1;
      end else if (++n > 50) begin
        checkOutput("accept_timeout", i_ready[0], 1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idleCycle(input int rdy_pct);
    in_valid  = 1'b0;
    out_ready = ($urandom_range(99) < rdy_pct);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_valid[%0d]", tag, d), o_valid[d], 0);
      checkOutput($sformatf("%s_data[%0d]", tag, d), o_data[d], 0);
      checkOutput($sformatf("%s_par[%0d]", tag, d), o_par[d], 0);
      checkOutput($sformatf("%s_last[%0d]", tag, d), o_last[d], 0);
      checkOutput($sformatf("%s_trailer[%0d]", tag, d), o_trl[d], 0);
      checkOutput($sformatf("%s_err[%0d]", tag, d), o_err[d], 0);
      checkOutput($sformatf("%s_flen[%0d]", tag, d), o_flen[d], 0);
      checkOutput($sformatf("%s_ecnt[%0d]", tag, d), o_ecnt[d], 0);
      checkOutput($sformatf("%s_ready[%0d]", tag, d), i_ready[d], 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [DATA_W-1:0] w;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;

    // Two-word frame with an always-ready sink; in_ready drops for exactly the trailer cycle.
    applyStimulus(8'h03, 1'b0, 1'b0, 100);
    applyStimulus(8'h01, 1'b1, 1'b1, 100);
    @(negedge clk);
    checkOutput("trailer_ready_low", i_ready[0], 0);
    @(negedge clk);
    checkOutput("trailer_ready_back", i_ready[0], 1);
    @(posedge clk);
    #1;

    applyStimulus(8'hFF, 1'b1, 1'b0, 100);
    applyStimulus(8'h07, 1'b0, 1'b0, 100);
    applyStimulus(8'h07, 1'b1, 1'b1, 100);

    // Backpressure: sink stalls five cycles while the next word waits.
    applyStimulus(8'hA5, 1'b0, 1'b0, 100);
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_last   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_ready_low%0d", i), i_ready[0], 0);
      @(posedge clk);
      #1;
    end
    applyStimulus(8'h5A, 1'b0, 1'b0, 100);
    applyStimulus(8'h3C, 1'b1, 1'b0, 100);

    // Reset mid-frame after three words, then a clean frame.
    applyStimulus(8'h11, 1'b0, 1'b0, 100);
    applyStimulus(8'h22, 1'b0, 1'b0, 100);
    applyStimulus(8'h44, 1'b0, 1'b0, 100);
    #2 rst = 1'b1;
    #1 checkResetValues("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'h0F, 1'b0, 1'b0, 100);
    applyStimulus(8'hF0, 1'b1, 1'b0, 100);

    // Random frames, random sink readiness and idle gaps; lengths exceed the 2-bit counter.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(10, 1);
      int rdy = $urandom_range(100, 30);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3) == 0) idleCycle(rdy);
        applyStimulus(DATA_W'($urandom), (k == len - 1), 1'($urandom), rdy);
      end
    end

    // 300 words with wrong even parity so the checker count saturates.
    for (int k = 0; k < 300; k++) begin
      w = DATA_W'($urandom);
      applyStimulus(w, (k % 20) == 19, ~(^w), 100);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idleCycle(100);
      n++;
    end
    checkOutput("drain_empty", sb.size(), 0);
    @(negedge clk);
`ifdef PARITY_CHECK_EN
    checkOutput("err_cnt_saturated", o_ecnt[0], 255);
`else
    checkOutput("err_cnt_disabled", o_ecnt[0], 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
